// File: rtl/elevator_pkg.sv
// Shared constants for the elevator call panel: floor one-hot codes, door states, default floor count.
package elevator_pkg;

    localparam int NFLR_DEF = 5;

    localparam logic [4:0] FL1 = 5'b00001;
    localparam logic [4:0] FL2 = 5'b00010;
    localparam logic [4:0] FL3 = 5'b00100;
    localparam logic [4:0] FL4 = 5'b01000;
    localparam logic [4:0] FL5 = 5'b10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } door_state_e;

endpackage

// File: rtl/elevator_call_panel_call_latch.sv
// Button rising-edge detector and request lamp register; a clear on a bit beats a same-cycle press.
module call_latch
    import elevator_pkg::*;
#(
    parameter int NFLR = NFLR_DEF
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NFLR-1:0] btn,
    input  logic [NFLR-1:0] clr,
    output logic [NFLR-1:0] rise,
    output logic [NFLR-1:0] lamp_reg
);

    logic [NFLR-1:0] btn_q;
    logic [NFLR-1:0] lamp_q;
    logic [NFLR-1:0] lamp_d;

    assign rise     = btn & ~btn_q;
    assign lamp_d   = (lamp_q | rise) & ~clr;
    assign lamp_reg = lamp_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            btn_q  <= '0;
            lamp_q <= '0;
        end else begin
            btn_q  <= btn;
            lamp_q <= lamp_d;
        end
    end

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel top: request latching, door open/close FSM and lamp mux for the floor FSM.
// Optional served-call counter enabled by defining PANEL_SVC_CNT_EN.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int NFLR  = NFLR_DEF,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NFLR-1:0] btn,
    input  logic [NFLR-1:0] car_flr,
    output logic [NFLR-1:0] lamp,
    output logic            door_open,
    output logic [15:0]     svc_cnt
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    door_state_e     state_q, state_d;
    logic [NFLR-1:0] open_flr_q, open_flr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NFLR-1:0] car_q;
    logic            door_open_q;
    logic [NFLR-1:0] rise;
    logic [NFLR-1:0] lamp_reg;
    logic [NFLR-1:0] clr;
    logic            valid_flr;
    logic            stopped;
    logic            reopen;

    call_latch #(.NFLR(NFLR)) u_call_latch (
        .clk      (clk),
        .nrst     (nrst),
        .btn      (btn),
        .clr      (clr),
        .rise     (rise),
        .lamp_reg (lamp_reg)
    );

    assign valid_flr = (car_flr != '0) && ((car_flr & (car_flr - 1'b1)) == '0);
    assign stopped   = valid_flr && (car_flr == car_q);
    assign reopen    = |(rise & open_flr_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        open_flr_d = open_flr_q;
        cnt_d      = cnt_q;
        clr        = '0;
        case (state_q)
            IDLE: begin
                if (stopped && |(lamp_reg & car_flr)) begin
                    state_d    = OPEN;
                    open_flr_d = car_flr;
                    cnt_d      = DWELL_M1;
                    clr        = car_flr;
                end
            end
            OPEN: begin
                // Presses at the open floor extend the door instead of re-arming the lamp.
                clr = open_flr_q;
                if (reopen)
                    cnt_d = DWELL_M1;
                else if (cnt_q == '0)
                    state_d = CLOSE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            CLOSE: begin
                clr = open_flr_q;
                if (reopen) begin
                    state_d = OPEN;
                    cnt_d   = DWELL_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            open_flr_q  <= '0;
            cnt_q       <= '0;
            car_q       <= '0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            open_flr_q  <= open_flr_d;
            cnt_q       <= cnt_d;
            car_q       <= car_flr;
            door_open_q <= (state_d == OPEN);
        end
    end

    // While the door is busy only the door floor is requested, which pins the car in place.
    assign lamp      = (state_q == IDLE) ? lamp_reg : open_flr_q;
    assign door_open = door_open_q;

`ifdef PANEL_SVC_CNT_EN
    logic [15:0] svc_cnt_q;
    logic        svc_inc;

    assign svc_inc = (state_q == CLOSE) && (state_d == IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            svc_cnt_q <= '0;
        else if (svc_inc && (svc_cnt_q != 16'hFFFF))
            svc_cnt_q <= svc_cnt_q + 16'd1;
    end

    assign svc_cnt = svc_cnt_q;
`else
    assign svc_cnt = '0;
`endif

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel: vector table for the main flow, hand sequences for corner cases.
module tb_elevator_call_panel;
    import elevator_pkg::*;

    localparam int NF = 5;
    localparam int DW = 4;
`ifdef PANEL_SVC_CNT_EN
    localparam bit SVC_EN = 1'b1;
`else
    localparam bit SVC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic [NF-1:0] btn;
    logic [NF-1:0] car_flr;
    logic [NF-1:0] lamp;
    logic          door_open;
    logic [15:0]   svc_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NF-1:0] btn;
        logic [NF-1:0] car;
        logic [NF-1:0] lamp;
        logic          door;
        int            svc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    elevator_call_panel #(.NFLR(NF), .DWELL(DW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .btn       (btn),
        .car_flr   (car_flr),
        .lamp      (lamp),
        .door_open (door_open),
        .svc_cnt   (svc_cnt)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [NF-1:0] l, input logic d, input int s);
        check({tag, " lamp"}, 16'(lamp), 16'(l));
        check({tag, " door_open"}, 16'(door_open), 16'(d));
        check({tag, " svc_cnt"}, svc_cnt, SVC_EN ? 16'(s) : 16'd0);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step(input logic [NF-1:0] b, input logic [NF-1:0] c);
        btn     = b;
        car_flr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [NF-1:0] b, input logic [NF-1:0] c,
                       input logic [NF-1:0] l, input logic d, input int s);
        vecs.push_back('{btn: b, car: c, lamp: l, door: d, svc: s});
    endtask

    initial begin
        // Request latch at floor 4 while the car sits at floor 1
        add(5'b0, FL1, 5'b0, 0, 0);
        add(FL4,  FL1, FL4,  0, 0);
        add(FL4,  FL1, FL4,  0, 0);
        add(FL4,  FL1, FL4,  0, 0);
        add(5'b0, FL1, FL4,  0, 0);
        add(5'b0, FL1, FL4,  0, 0);
        // Basic service: car arrives at floor 4
        add(5'b0, FL4, FL4,  0, 0);
        add(5'b0, FL4, FL4,  1, 0);
        add(5'b0, FL4, FL4,  1, 0);
        add(5'b0, FL4, FL4,  1, 0);
        add(5'b0, FL4, FL4,  1, 0);
        add(5'b0, FL4, FL4,  0, 0);
        add(5'b0, FL4, 5'b0, 0, 1);
        add(5'b0, FL4, 5'b0, 0, 1);
        // Extension: re-press at the open floor in the 2nd OPEN cycle
        add(FL4,  FL4, FL4,  0, 1);
        add(5'b0, FL4, FL4,  1, 1);
        add(5'b0, FL4, FL4,  1, 1);
        add(FL4,  FL4, FL4,  1, 1);
        add(5'b0, FL4, FL4,  1, 1);
        add(5'b0, FL4, FL4,  1, 1);
        add(5'b0, FL4, FL4,  1, 1);
        add(5'b0, FL4, FL4,  0, 1);
        add(5'b0, FL4, 5'b0, 0, 2);
        // Cross-floor press during the door sequence
        add(FL4,  FL4, FL4,  0, 2);
        add(5'b0, FL4, FL4,  1, 2);
        add(FL3,  FL4, FL4,  1, 2);
        add(5'b0, FL4, FL4,  1, 2);
        add(5'b0, FL4, FL4,  1, 2);
        add(5'b0, FL4, FL4,  0, 2);
        add(5'b0, FL4, FL3,  0, 3);
        add(5'b0, FL4, FL3,  0, 3);
        // Invalid floor: multi-hot then zero car_flr
        add(FL2,  FL5, FL3 | FL2, 0, 3);
        for (int i = 0; i < 5; i++) add(5'b0, FL3 | FL2, FL3 | FL2, 0, 3);
        add(5'b0, 5'b0, FL3 | FL2, 0, 3);
        add(5'b0, 5'b0, FL3 | FL2, 0, 3);

        nrst    = 1'b0;
        btn     = '0;
        car_flr = FL1;
        #2;
        expect_out("reset", 5'b0, 1'b0, 0);
        #10;
        nrst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].btn, vecs[i].car);
            expect_out($sformatf("vec%0d", i), vecs[i].lamp, vecs[i].door, vecs[i].svc);
        end

        // Service at floor 3 with car_flr going invalid mid-door, plus a reopen from CLOSE
        step(5'b0, FL3);  expect_out("inv arrive", FL3 | FL2, 1'b0, 3);
        step(5'b0, FL3);  expect_out("inv open", FL3, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            step(5'b0, 5'b0);
            expect_out($sformatf("inv hold%0d", i), FL3, 1'b1, 3);
        end
        step(5'b0, 5'b0); expect_out("inv close", FL3, 1'b0, 3);
        step(FL3, 5'b0);  expect_out("close reopen", FL3, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            step(5'b0, 5'b0);
            expect_out($sformatf("reopen hold%0d", i), FL3, 1'b1, 3);
        end
        step(5'b0, 5'b0); expect_out("reopen close", FL3, 1'b0, 3);
        step(5'b0, 5'b0); expect_out("reopen idle", FL2, 1'b0, 4);

        // Asynchronous reset in the middle of an OPEN with another call pending
        step(5'b0, FL2);  expect_out("rst arrive", FL2, 1'b0, 4);
        step(5'b0, FL2);  expect_out("rst open", FL2, 1'b1, 4);
        step(FL5, FL2);   expect_out("rst pend", FL2, 1'b1, 4);
        #2;
        nrst = 1'b0;
        #1;
        expect_out("mid reset", 5'b0, 1'b0, 0);
        #2;
        nrst = 1'b1;
        step(5'b0, FL2);  expect_out("post rst a", 5'b0, 1'b0, 0);
        step(5'b0, FL2);  expect_out("post rst b", 5'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
